// File: rtl/sseg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-coherent snapshot
// of the BCD digits, leading-zero blanking and active-low registered outputs.
module sseg_digit_nz (
  input  logic [3:0] digit,
  output logic       nz
);
  assign nz = |digit;
endmodule

module sseg_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PS_MAX  = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]                 ps;
  logic [IW-1:0]                 idx;
  logic                          primed;
  logic [NUM_DIGITS-1:0][3:0]    snap_dig;
  logic [NUM_DIGITS-1:0]         snap_dp;
  logic                          snap_lz;
  logic                          slot_tick, wrap, capture;
  logic [NUM_DIGITS-1:0]         nz, blank;
  logic                          any_nz;
  logic [3:0]                    cur;
  logic [6:0]                    dec;

  assign slot_tick = enable && (ps == PS_MAX);
  assign wrap      = slot_tick && (idx == IDX_MAX);
  // Snapshot on frame boundary, plus once on the first enabled cycle so the
  // very first frame shows real data.
  assign capture   = enable && (wrap || !primed);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps         <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (enable) begin
        ps <= slot_tick ? '0 : ps + PW'(1);
        if (slot_tick) idx <= wrap ? '0 : idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      primed   <= 1'b0;
      snap_dig <= '0;
      snap_dp  <= '0;
      snap_lz  <= 1'b0;
    end else if (capture) begin
      primed   <= 1'b1;
      snap_dig <= digits_in;
      snap_dp  <= dp_in;
      snap_lz  <= lz_blank_en;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nz
    sseg_digit_nz u_nz (.digit(snap_dig[g]), .nz(nz[g]));
  end

  // A digit is blanked when it and everything above it is zero; digit 0 never.
  always_comb begin
    any_nz = 1'b0;
    blank  = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      any_nz   = any_nz | nz[k];
      blank[k] = snap_lz & ~any_nz;
    end
  end

  assign cur = snap_dig[idx];

  always_comb begin
    dec = 7'b0111111;
    case (cur)
      4'd0: dec = 7'b1000000;
      4'd1: dec = 7'b1111001;
      4'd2: dec = 7'b0100100;
      4'd3: dec = 7'b0110000;
      4'd4: dec = 7'b0011001;
      4'd5: dec = 7'b0010010;
      4'd6: dec = 7'b0000010;
      4'd7: dec = 7'b1111000;
      4'd8: dec = 7'b0000000;
      4'd9: dec = 7'b0010000;
      default: dec = 7'b0111111;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else if (enable && primed) begin
      an  <= ~(NUM_DIGITS'(1) << idx);
      seg <= blank[idx] ? 7'h7F : dec;
      dp  <= ~snap_dp[idx];
    end else begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end
  end
endmodule
